// File: rtl/cmd_sched_pkg.sv
// Shared types and constants for the pin-state command scheduler.
package cmd_sched_pkg;

  localparam int unsigned MEM_W  = 6;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WRITE   = 2'd1,
    TX_REQ  = 2'd2,
    TX_WAIT = 2'd3
  } state_e;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_RD  = 2'b01;
  localparam logic [1:0] OP_WR  = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;

  localparam logic [1:0] TAG_RD  = 2'b01;
  localparam logic [1:0] TAG_WR  = 2'b10;
  localparam logic [1:0] TAG_KEY = 2'b11;

  localparam logic [BYTE_W-1:0] RST_BYTE = 8'h00;
  localparam logic [BYTE_W-1:0] ERR_BYTE = 8'hFF;

  typedef struct packed {
    logic [1:0]       op;
    logic [MEM_W-1:0] payload;
  } cmd_t;

  function automatic logic [BYTE_W-1:0] resp(input logic [1:0] tag, input logic [MEM_W-1:0] d);
    return {tag, d};
  endfunction

endpackage

// File: rtl/cmd_sched_if.sv
// Memory write handshake and UART transmit handshake between scheduler and its peers.
interface cmd_sched_if;
  import cmd_sched_pkg::*;

  logic [MEM_W-1:0]  mem;
  logic              mem_wrt_rd;
  logic              mem_wrt_en;
  logic [MEM_W-1:0]  mem_out;
  logic              rx_busy;
  logic              rx_start;
  logic              rx_done;
  logic [BYTE_W-1:0] tx_data;

  modport master (
    input  mem, mem_wrt_rd, rx_busy, rx_done,
    output mem_wrt_en, mem_out, rx_start, tx_data
  );

  modport slave (
    output mem, mem_wrt_rd, rx_busy, rx_done,
    input  mem_wrt_en, mem_out, rx_start, tx_data
  );
endinterface

// File: rtl/cmd_sched_req_latch.sv
// One-deep pending request latch; a pulse that finds the latch still full is dropped.
module req_latch #(
  parameter int unsigned DW = 1
) (
  input  logic          in_clk,
  input  logic          in_rst,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic          pend,
  output logic [DW-1:0] dout,
  output logic          drop_c
);

  logic          pend_q, pend_d;
  logic [DW-1:0] data_q, data_d;

  // A push coinciding with the clear refills the latch instead of dropping.
  always_comb begin
    drop_c = push & pend_q & ~clr;
    pend_d = pend_q & ~clr;
    data_d = data_q;
    if (push && !drop_c) begin
      pend_d = 1'b1;
      data_d = din;
    end
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      pend_q <= 1'b0;
      data_q <= '0;
    end else begin
      pend_q <= pend_d;
      data_q <= data_d;
    end
  end

  assign pend = pend_q;
  assign dout = data_q;

endmodule

// File: rtl/cmd_sched.sv
// Prioritises UART, key and reset-button requests, sequences the memory write
// handshake and sends one response byte per serviced request.
module cmd_sched import cmd_sched_pkg::*; #(
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned W           = MEM_W
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             uart_push,
  input  logic [7:0]       i_uart_data,
  input  logic             key_push,
  input  logic [2:0]       key_idx,
  input  logic             reset_push,
  cmd_sched_if.master      bus,
  output logic             sched_busy,
  output logic             err,
  output logic [CNT_W-1:0] drop_cnt
);

  localparam int unsigned TMR_W = 8;

  state_e            state_q, state_d;
  logic              mem_wrt_en_q, mem_wrt_en_d;
  logic [W-1:0]      mem_out_q, mem_out_d;
  logic              rx_start_q, rx_start_d;
  logic [BYTE_W-1:0] tx_data_q, tx_data_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;
  logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
  logic [TMR_W-1:0]  timer_q, timer_d;

  logic       sel_rst, sel_uart, sel_key, ignore_c;
  logic       rst_pend, rst_mark, rst_drop;
  logic       uart_pend, uart_drop;
  logic [7:0] uart_cmd;
  logic       key_pend, key_drop;
  logic [2:0] key_sel;
  cmd_t       cmd;
  logic [W-1:0] key_word;

  req_latch #(.DW(1)) u_rst_latch (
    .in_clk, .in_rst, .push(reset_push), .din(1'b1), .clr(sel_rst),
    .pend(rst_pend), .dout(rst_mark), .drop_c(rst_drop)
  );

  req_latch #(.DW(8)) u_uart_latch (
    .in_clk, .in_rst, .push(uart_push), .din(i_uart_data), .clr(sel_uart),
    .pend(uart_pend), .dout(uart_cmd), .drop_c(uart_drop)
  );

  req_latch #(.DW(3)) u_key_latch (
    .in_clk, .in_rst, .push(key_push), .din(key_idx), .clr(sel_key),
    .pend(key_pend), .dout(key_sel), .drop_c(key_drop)
  );

  assign cmd      = cmd_t'(uart_cmd);
  assign key_word = bus.mem ^ (W'(1) << key_sel);

  // Scheduler next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    mem_wrt_en_d = mem_wrt_en_q;
    mem_out_d    = mem_out_q;
    rx_start_d   = 1'b0;
    tx_data_d    = tx_data_q;
    err_d        = err_q;
    timer_d      = timer_q;
    sel_rst      = 1'b0;
    sel_uart     = 1'b0;
    sel_key      = 1'b0;
    ignore_c     = 1'b0;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (rst_pend && rst_mark) begin
          sel_rst      = 1'b1;
          mem_out_d    = '0;
          tx_data_d    = RST_BYTE;
          mem_wrt_en_d = 1'b1;
          state_d      = WRITE;
        end else if (uart_pend) begin
          sel_uart = 1'b1;
          case (cmd.op)
            OP_RD: begin
              tx_data_d  = resp(TAG_RD, bus.mem);
              rx_start_d = ~bus.rx_busy;
              state_d    = TX_REQ;
            end
            OP_WR: begin
              mem_out_d    = cmd.payload;
              tx_data_d    = resp(TAG_WR, cmd.payload);
              mem_wrt_en_d = 1'b1;
              state_d      = WRITE;
            end
            OP_CLR: begin
              mem_out_d    = '0;
              tx_data_d    = resp(TAG_WR, '0);
              mem_wrt_en_d = 1'b1;
              state_d      = WRITE;
            end
            OP_NOP: ;
            default: ;
          endcase
        end else if (key_pend) begin
          sel_key = 1'b1;
          if (32'(key_sel) >= W) begin
            ignore_c = 1'b1;
          end else begin
            mem_out_d    = key_word;
            tx_data_d    = resp(TAG_KEY, key_word);
            mem_wrt_en_d = 1'b1;
            state_d      = WRITE;
          end
        end
      end
      WRITE: begin
        if (bus.mem_wrt_rd) begin
          mem_wrt_en_d = 1'b0;
          err_d        = 1'b0;
          state_d      = TX_REQ;
        end else if (timer_q == TMR_W'(ACK_TIMEOUT - 1)) begin
          mem_wrt_en_d = 1'b0;
          err_d        = 1'b1;
          tx_data_d    = ERR_BYTE;
          state_d      = TX_REQ;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      // A start already issued from IDLE is consumed here; otherwise wait for the transmitter.
      TX_REQ: begin
        if (rx_start_q) begin
          state_d = TX_WAIT;
        end else if (!bus.rx_busy) begin
          rx_start_d = 1'b1;
        end
      end
      TX_WAIT: begin
        if (bus.rx_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);

    drop_cnt_d = drop_cnt_q;
    if ((rst_drop | uart_drop | key_drop | ignore_c) && (drop_cnt_q != '1))
      drop_cnt_d = drop_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state_q      <= IDLE;
      mem_wrt_en_q <= 1'b0;
      mem_out_q    <= '0;
      rx_start_q   <= 1'b0;
      tx_data_q    <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      drop_cnt_q   <= '0;
      timer_q      <= '0;
    end else begin
      state_q      <= state_d;
      mem_wrt_en_q <= mem_wrt_en_d;
      mem_out_q    <= mem_out_d;
      rx_start_q   <= rx_start_d;
      tx_data_q    <= tx_data_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      drop_cnt_q   <= drop_cnt_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.mem_wrt_en = mem_wrt_en_q;
  assign bus.mem_out    = mem_out_q;
  assign bus.rx_start   = rx_start_q;
  assign bus.tx_data    = tx_data_q;
  assign sched_busy     = busy_q;
  assign err            = err_q;
  assign drop_cnt       = drop_cnt_q;

endmodule

// File: tb/tb_cmd_sched.sv
// Scoreboard bench for cmd_sched: stimulus pushes expected writes/responses, models pop and compare.
module tb_cmd_sched;
  import cmd_sched_pkg::*;

  localparam int unsigned ACK_TO = 16;

  logic       in_clk = 1'b0;
  logic       in_rst = 1'b0;
  logic       uart_push = 1'b0;
  logic [7:0] i_uart_data = 8'h00;
  logic       key_push = 1'b0;
  logic [2:0] key_idx = 3'd0;
  logic       reset_push = 1'b0;
  logic       sched_busy, err;
  logic [7:0] drop_cnt;

  cmd_sched_if bif();

  cmd_sched #(.ACK_TIMEOUT(ACK_TO)) dut (
    .in_clk(in_clk), .in_rst(in_rst), .uart_push(uart_push), .i_uart_data(i_uart_data),
    .key_push(key_push), .key_idx(key_idx), .reset_push(reset_push), .bus(bif),
    .sched_busy(sched_busy), .err(err), .drop_cnt(drop_cnt)
  );

  initial forever #5 in_clk = ~in_clk;

  typedef struct { logic [5:0] data; int cycles; } wr_t;
  wr_t        exp_wr[$];
  logic [7:0] exp_tx[$];
  int n_chk = 0;
  int n_pass = 0;
  bit ack_en = 1'b1;
  int ack_dly = 3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
  endtask

  // Memory model: acknowledges after ack_dly enabled cycles, checks each write on its falling enable.
  initial begin : mem_model
    int en_cnt;
    logic prev_en;
    logic unstable;
    logic [5:0] cap;
    wr_t w;
    en_cnt = 0; prev_en = 1'b0; unstable = 1'b0; cap = '0;
    bif.mem_wrt_rd = 1'b0;
    forever begin
      @(negedge in_clk);
      bif.mem_wrt_rd = 1'b0;
      if (!in_rst) begin
        prev_en = 1'b0;
        en_cnt  = 0;
      end else if (bif.mem_wrt_en) begin
        if (!prev_en) begin
          cap = bif.mem_out;
          unstable = 1'b0;
        end else if (bif.mem_out != cap) begin
          unstable = 1'b1;
        end
        en_cnt++;
        if (ack_en && en_cnt == ack_dly) bif.mem_wrt_rd = 1'b1;
        prev_en = 1'b1;
      end else if (prev_en) begin
        prev_en = 1'b0;
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", 32'(cap), 32'hFFFF_FFFF);
        end else begin
          w = exp_wr.pop_front();
          chk("wr_data", 32'(cap), 32'(w.data));
          chk("wr_en_cycles", 32'(en_cnt), 32'(w.cycles));
          chk("wr_data_stable", 32'(unstable), 32'd0);
        end
        en_cnt = 0;
      end
    end
  end

  // Transmitter model: busy for 8 cycles after each start, then pulses rx_done.
  initial begin : tx_model
    int cnt;
    logic [7:0] cap;
    cnt = 0; cap = '0;
    bif.rx_busy = 1'b0;
    bif.rx_done = 1'b0;
    forever begin
      @(negedge in_clk);
      bif.rx_done = 1'b0;
      if (!in_rst) begin
        cnt = 0;
        bif.rx_busy = 1'b0;
      end else begin
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            bif.rx_done = 1'b1;
            bif.rx_busy = 1'b0;
            chk("tx_hold", 32'(bif.tx_data), 32'(cap));
          end
        end
        if (bif.rx_start) begin
          if (cnt != 0) chk("start_while_busy", 32'(cnt), 32'd0);
          cap = bif.tx_data;
          if (exp_tx.size() == 0) chk("unexpected_tx", 32'(bif.tx_data), 32'hFFFF_FFFF);
          else chk("tx_data", 32'(bif.tx_data), 32'(exp_tx.pop_front()));
          bif.rx_busy = 1'b1;
          cnt = 8;
        end
      end
    end
  end

  task automatic uart(input logic [7:0] b);
    @(negedge in_clk);
    uart_push = 1'b1; i_uart_data = b;
    @(negedge in_clk);
    uart_push = 1'b0;
  endtask

  task automatic key(input logic [2:0] idx);
    @(negedge in_clk);
    key_push = 1'b1; key_idx = idx;
    @(negedge in_clk);
    key_push = 1'b0;
  endtask

  task automatic exp_write(input logic [5:0] d, input int cyc, input logic [7:0] t);
    wr_t w;
    w.data = d; w.cycles = cyc;
    exp_wr.push_back(w);
    exp_tx.push_back(t);
  endtask

  task automatic wait_idle(input string name);
    int quiet, n;
    quiet = 0; n = 0;
    while (quiet < 4 && n < 2000) begin
      @(negedge in_clk);
      n++;
      if (!sched_busy && exp_tx.size() == 0 && exp_wr.size() == 0) quiet++;
      else quiet = 0;
    end
    chk({name, "_done_in_budget"}, 32'(n < 2000), 32'd1);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int n, busy_cycles;
    bif.mem = 6'd21;
    repeat (3) @(negedge in_clk);
    chk("rst_mem_wrt_en", 32'(bif.mem_wrt_en), 32'd0);
    chk("rst_mem_out", 32'(bif.mem_out), 32'd0);
    chk("rst_rx_start", 32'(bif.rx_start), 32'd0);
    chk("rst_tx_data", 32'(bif.tx_data), 32'd0);
    chk("rst_sched_busy", 32'(sched_busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
    in_rst = 1'b1;
    repeat (2) @(negedge in_clk);

    // Key toggle of bit 0: 21 -> 20, response {11,20}.
    exp_write(6'd20, 3, 8'hD4);
    key(3'd0);
    wait_idle("t1");

    // Read then write 21.
    exp_tx.push_back(8'h55);
    uart(8'h55);
    wait_idle("t2_read");
    exp_write(6'd21, 3, 8'h95);
    uart(8'h95);
    wait_idle("t2_write");

    // Three sources in one cycle: reset, then UART read, then key bit 1.
    exp_write(6'd0, 3, 8'h00);
    exp_tx.push_back(8'h55);
    exp_write(6'd23, 3, 8'hD7);
    @(negedge in_clk);
    uart_push = 1'b1; i_uart_data = 8'h40; key_push = 1'b1; key_idx = 3'd1; reset_push = 1'b1;
    @(negedge in_clk);
    uart_push = 1'b0; key_push = 1'b0; reset_push = 1'b0;
    wait_idle("t3");
    chk("t3_drop_cnt", 32'(drop_cnt), 32'd0);

    // Write timeout, then an acknowledged write clears err.
    ack_en = 1'b0;
    exp_write(6'd10, ACK_TO, 8'hFF);
    uart(8'h8A);
    wait_idle("t4_timeout");
    chk("t4_err_set", 32'(err), 32'd1);
    ack_en = 1'b1;
    exp_write(6'd11, 3, 8'h8B);
    uart(8'h8B);
    wait_idle("t4_ack");
    chk("t4_err_clr", 32'(err), 32'd0);

    // Two key pulses during TX_WAIT: first served after the read, second dropped.
    exp_tx.push_back(8'h55);
    exp_write(6'd17, 3, 8'hD1);
    uart(8'h40);
    n = 0;
    while (!bif.rx_start && n < 50) begin
      @(negedge in_clk);
      n++;
    end
    chk("t5_start_seen", 32'(n < 50), 32'd1);
    @(negedge in_clk);
    key(3'd2);
    key(3'd3);
    wait_idle("t5");
    chk("t5_drop_one", 32'(drop_cnt), 32'd1);

    // Flood with out-of-range key pulses until the counter saturates.
    @(negedge in_clk);
    key_push = 1'b1; key_idx = 3'd7;
    repeat (300) @(negedge in_clk);
    key_push = 1'b0;
    wait_idle("t5_flood");
    chk("t5_drop_sat", 32'(drop_cnt), 32'd255);

    // Asynchronous reset in the middle of a write.
    ack_en = 1'b0;
    uart(8'h85);
    n = 0;
    while (!bif.mem_wrt_en && n < 20) begin
      @(negedge in_clk);
      n++;
    end
    chk("t6_write_started", 32'(bif.mem_wrt_en), 32'd1);
    @(negedge in_clk);
    #2 in_rst = 1'b0;
    #1;
    chk("t6_async_wrt_en", 32'(bif.mem_wrt_en), 32'd0);
    chk("t6_async_rx_start", 32'(bif.rx_start), 32'd0);
    chk("t6_async_busy", 32'(sched_busy), 32'd0);
    chk("t6_async_drop_cnt", 32'(drop_cnt), 32'd0);
    repeat (3) @(negedge in_clk);
    in_rst = 1'b1;
    ack_en = 1'b1;
    busy_cycles = 0;
    repeat (30) begin
      @(negedge in_clk);
      if (sched_busy || bif.mem_wrt_en) busy_cycles++;
    end
    chk("t6_quiet_after_release", 32'(busy_cycles), 32'd0);
    chk("t6_err_after_release", 32'(err), 32'd0);
    chk("t6_queues_empty", 32'(exp_tx.size() + exp_wr.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
